// File: rtl/pipelined_sub32.sv
// Two-stage pipelined subtractor: diff = a - b (mod 2^WIDTH) with unsigned borrow and signed overflow.
// Latency 2 clocks from input transfer to out_valid; one result per clock when out_ready is high.
// Backpressure: holds up to two operations (stage 1 + output); in_ready drops only when both are occupied.
module pipelined_sub32 #(
  parameter int WIDTH = 32,
  parameter int LOW_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int HIGH_W = WIDTH - LOW_W;

  // Everything stage 2 needs: the untouched high operand halves plus the finished low half.
  typedef struct packed {
    logic [HIGH_W-1:0] a_hi;
    logic [HIGH_W-1:0] b_hi;
    logic [LOW_W-1:0]  dlo;
    logic              bl;
  } s1_t;

  s1_t              s1_d;
  s1_t              s1_q;
  logic             s1_vld;
  logic             s2_free;
  logic             s2_load;
  logic             in_xfer;
  logic [LOW_W:0]   lo_res;
  logic [HIGH_W:0]  hi_res;
  logic             ovf_d;

  // Output slot can take a new result when empty or being drained this cycle.
  always_comb begin
    s2_free  = !out_valid || out_ready;
    s2_load  = s1_vld && s2_free;
    in_ready = !s1_vld || s2_free;
    in_xfer  = in_valid && in_ready;
  end

  // Low-half subtract on incoming operands; its borrow-out is carried into stage 2.
  always_comb begin
    lo_res    = {1'b0, a[LOW_W-1:0]} - {1'b0, b[LOW_W-1:0]};
    s1_d.a_hi = a[WIDTH-1:LOW_W];
    s1_d.b_hi = b[WIDTH-1:LOW_W];
    s1_d.dlo  = lo_res[LOW_W-1:0];
    s1_d.bl   = lo_res[LOW_W];
  end

  // High-half subtract folding in the registered low borrow; overflow uses the operand sign bits.
  always_comb begin
    hi_res = {1'b0, s1_q.a_hi} - {1'b0, s1_q.b_hi} - {{HIGH_W{1'b0}}, s1_q.bl};
    ovf_d  = (s1_q.a_hi[HIGH_W-1] != s1_q.b_hi[HIGH_W-1]) &&
             (hi_res[HIGH_W-1] != s1_q.a_hi[HIGH_W-1]);
  end

  // Stage 1 register: loads on input transfer, empties when stage 2 takes its contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
    end else begin
      if (in_xfer) begin
        s1_vld <= 1'b1;
        s1_q   <= s1_d;
      end else if (s2_load) begin
        s1_vld <= 1'b0;
      end
    end
  end

  // Output register: a new result may replace one leaving in the same cycle; otherwise it holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        diff      <= {hi_res[HIGH_W-1:0], s1_q.dlo};
        borrow    <= hi_res[HIGH_W];
        ovf       <= ovf_d;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
